ps2_key_event_ctrl: RTL and testbench

//  Scan-code sequencer between the PS/2 receiver and the application logic. It consumes received bytes
//  (rx_data + rx_done pulse) and parses the set-2 prefix sequences E0 (extended) and F0 (break).

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_evt_fifo.sv | 113 +++++++++++
 rtl/ps2_key_event_ctrl.sv | 136 +++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key-event path:
//   PFX_EXT / PFX_BRK  set-2 prefix bytes (extended, break)
//   ST_*               scan-sequencer state encoding
//   ps2_evt_t          event record {ext, brk, code[7:0]}, EVT_W bits wide
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    localparam int EVT_W = 10;

    // bit0 = "E0 seen", bit1 = "F0 seen"; a prefix byte simply ORs in its bit.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_EXT     = 2'b01;
    localparam logic [1:0] ST_BRK     = 2'b10;
    localparam logic [1:0] ST_EXT_BRK = 2'b11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic ps2_evt_t mk_evt(input logic ext, input logic brk, input logic [7:0] code);
        ps2_evt_t e;
        e.ext  = ext;
        e.brk  = brk;
        e.code = code;
        return e;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ---------------------------------------------------------------------------
// ps2_evt_fifo
// Synchronous first-word-fall-through FIFO with a registered head output and
// a sticky overflow flag.
//   clk, rst   clock, synchronous active-low reset
//   wr_en/din  push request and data (dropped when full without a pop)
//   rd_en      pop request (ignored while empty)
//   ovf_clr    clears ovf; a drop in the same cycle keeps it set
//   dout       registered head entry (zero while empty)
//   valid      FIFO not empty
//   ovf        sticky overflow
// ---------------------------------------------------------------------------
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = EVT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         rd_en,
    input  logic         ovf_clr,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;

    logic full, empty, do_push, do_pop;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == (AW+1)'(DEPTH));
        do_pop  = rd_en && !empty;
        // a pop frees the slot in the same cycle, so a full FIFO still accepts
        do_push = wr_en && (!full || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + AW'(1);

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        if (wr_en && !do_push)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;

        // Head register looks one write ahead: when the queue is (or becomes)
        // empty apart from this push, the new head is din, not yet in mem_q.
        valid_d = (cnt_d != '0);
        head_d  = '0;
        if (cnt_d != '0) begin
            if (do_push && (empty || (do_pop && cnt_q == (AW+1)'(1))))
                head_d = din;
            else
                head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign dout  = head_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_event_ctrl
// Turns raw set-2 scan bytes into key events {ext, brk, code}: E0/F0 prefix
// bytes are absorbed by a small sequencer, a stalled prefix sequence is
// aborted after TIMEOUT_CYC idle cycles, and finished events are queued in
// an FWFT FIFO popped with evt_rd.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rx_data, rx_done    received byte and its one-cycle strobe
//   evt_rd              pop head event (ignored while evt_valid=0)
//   evt_valid           head event present on evt_code/evt_ext/evt_brk
//   ovf, ovf_clr        sticky drop flag and its clear
// Optional build macro: PS2_TYPEMATIC_FILTER_EN -- suppress repeated make
// events of the same key until its break is seen.
// ---------------------------------------------------------------------------
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       evt_rd,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]       st_q, st_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic     raw_push;
    ps2_evt_t raw_evt;
    logic     push;
    ps2_evt_t head;

    // Sequencer + timeout
    always_comb begin
        st_d     = st_q;
        tmo_d    = '0;
        raw_push = 1'b0;
        raw_evt  = mk_evt(st_q[0], st_q[1], rx_data);

        if (rx_done) begin
            case (rx_data)
                PFX_EXT: st_d = st_q | ST_EXT;
                PFX_BRK: st_d = st_q | ST_BRK;
                default: begin
                    raw_push = 1'b1;
                    st_d     = ST_IDLE;
                end
            endcase
        end else if (st_q != ST_IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1))
                st_d = ST_IDLE;   // abandon the partial prefix silently
            else
                tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q  <= ST_IDLE;
            tmo_q <= '0;
        end else begin
            st_q  <= st_d;
            tmo_q <= tmo_d;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Remembers the last make {ext, code}; repeats of it are swallowed until
    // the matching break re-arms the key.
    logic [8:0] filt_key_q, filt_key_d;
    logic       filt_vld_q, filt_vld_d;
    logic       filt_hit;

    always_comb begin
        filt_key_d = filt_key_q;
        filt_vld_d = filt_vld_q;
        filt_hit   = filt_vld_q && (filt_key_q == {raw_evt.ext, raw_evt.code});
        push       = raw_push;
        if (raw_push) begin
            if (raw_evt.brk) begin
                if (filt_hit)
                    filt_vld_d = 1'b0;
            end else if (filt_hit) begin
                push = 1'b0;
            end else begin
                filt_key_d = {raw_evt.ext, raw_evt.code};
                filt_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_key_q <= '0;
            filt_vld_q <= 1'b0;
        end else begin
            filt_key_q <= filt_key_d;
            filt_vld_q <= filt_vld_d;
        end
    end
`else
    assign push = raw_push;
`endif

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .din     (raw_evt),
        .rd_en   (evt_rd),
        .ovf_clr (ovf_clr),
        .dout    (head),
        .valid   (evt_valid),
        .ovf     (ovf)
    );

    assign evt_code = head.code;
    assign evt_ext  = head.ext;
    assign evt_brk  = head.brk;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_ctrl
// Directed bench for ps2_key_event_ctrl (FIFO_DEPTH=4, TIMEOUT_CYC=16).
// Honours PS2_TYPEMATIC_FILTER_EN for the auto-repeat sequence.
// ---------------------------------------------------------------------------
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       evt_rd  = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid, evt_ext, evt_brk, ovf;
    logic [7:0] evt_code;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .evt_rd    (evt_rd),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_brk   (evt_brk),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic pop();
        evt_rd = 1'b1;
        tick();
        evt_rd = 1'b0;
    endtask

    // check head {ext,brk,code} then pop it
    task automatic expect_pop(input string tag, input logic [9:0] exp);
        chk({tag, "_vld"}, 16'(evt_valid), 16'h1);
        chk(tag, 16'({evt_ext, evt_brk, evt_code}), 16'(exp));
        pop();
    endtask

    logic [7:0] typ_seq [6];
    logic [9:0] typ_exp [5];
    int         typ_n;
    int         typ_got;

    initial begin
        // ---- reset state
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk("rst_vld",  16'(evt_valid), 16'h0);
        chk("rst_code", 16'(evt_code),  16'h0);
        chk("rst_ext",  16'(evt_ext),   16'h0);
        chk("rst_brk",  16'(evt_brk),   16'h0);
        chk("rst_ovf",  16'(ovf),       16'h0);

        // ---- single make, visible the cycle after rx_done
        send(8'h1C);
        expect_pop("make_1c", 10'h01C);
        chk("make_drained", 16'(evt_valid), 16'h0);

        // prefixes alone produce nothing
        send(8'hE0);
        chk("pfx_e0_none", 16'(evt_valid), 16'h0);
        send(8'hF0);
        chk("pfx_f0_none", 16'(evt_valid), 16'h0);
        send(8'h75);
        expect_pop("e0f0_75", 10'h375);

        // ---- prefix combinations, queued in order
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hE0); send(8'h6B);   // repeated E0 ignored
        expect_pop("seq_brk_1c",  10'h11C);
        expect_pop("seq_ext_75",  10'h275);
        expect_pop("seq_eb_75",   10'h375);
        expect_pop("seq_e0e0_6b", 10'h26B);
        send(8'hF0); send(8'hE0); send(8'h74);   // F0 then E0 -> ext+brk
        send(8'hF0); send(8'hF0); send(8'h12);   // repeated F0 ignored
        expect_pop("seq_f0e0_74", 10'h374);
        expect_pop("seq_f0f0_12", 10'h112);

        // ---- timeout boundary: TMO-1 idle cycles keep the prefix
        send(8'hE0);
        repeat (TMO - 1) tick();
        send(8'h75);
        expect_pop("tmo_edge_keep", 10'h275);
        // TMO idle cycles abort it
        send(8'hE0);
        repeat (TMO) tick();
        send(8'h1C);
        expect_pop("tmo_abort", 10'h01C);
        chk("tmo_none_left", 16'(evt_valid), 16'h0);
        chk("tmo_ovf",       16'(ovf),       16'h0);

        // ---- empty FIFO: simultaneous push+pop accepts the push
        rx_data = 8'h33; rx_done = 1'b1; evt_rd = 1'b1;
        tick();
        rx_done = 1'b0; evt_rd = 1'b0;
        expect_pop("empty_pushpop", 10'h033);

        // ---- fill, overflow, push+pop while full, ovf_clr priority
        for (int i = 1; i <= DEPTH; i++) send(8'(i));
        chk("full_no_ovf", 16'(ovf), 16'h0);
        send(8'h05);
        chk("ovf_set",  16'(ovf), 16'h1);
        chk("ovf_head", 16'({evt_ext, evt_brk, evt_code}), 16'h001);
        rx_data = 8'h06; rx_done = 1'b1; evt_rd = 1'b1;
        tick();
        rx_done = 1'b0; evt_rd = 1'b0;
        chk("full_pp_head", 16'({evt_ext, evt_brk, evt_code}), 16'h002);
        chk("full_pp_ovf",  16'(ovf), 16'h1);
        rx_data = 8'h07; rx_done = 1'b1; ovf_clr = 1'b1;  // drop wins over clear
        tick();
        rx_done = 1'b0;
        chk("drop_wins_clr", 16'(ovf), 16'h1);
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 16'(ovf), 16'h0);
        expect_pop("full_e0", 10'h002);
        expect_pop("full_e1", 10'h003);
        expect_pop("full_e2", 10'h004);
        expect_pop("full_e3", 10'h006);
        chk("full_drained", 16'(evt_valid), 16'h0);

        // ---- typematic sequence 1C 1C 1C F0 1C 1C
        typ_seq[0] = 8'h1C; typ_seq[1] = 8'h1C; typ_seq[2] = 8'h1C;
        typ_seq[3] = 8'hF0; typ_seq[4] = 8'h1C; typ_seq[5] = 8'h1C;
`ifdef PS2_TYPEMATIC_FILTER_EN
        typ_exp[0] = 10'h01C; typ_exp[1] = 10'h11C; typ_exp[2] = 10'h01C;
        typ_exp[3] = 10'h000; typ_exp[4] = 10'h000;
        typ_n = 3;
`else
        typ_exp[0] = 10'h01C; typ_exp[1] = 10'h01C; typ_exp[2] = 10'h01C;
        typ_exp[3] = 10'h11C; typ_exp[4] = 10'h01C;
        typ_n = 5;
`endif
        typ_got = 0;
        for (int i = 0; i < 6; i++) begin
            send(typ_seq[i]);
            if (evt_valid) begin
                if (typ_got < 5)
                    chk($sformatf("typ_evt%0d", typ_got),
                        16'({evt_ext, evt_brk, evt_code}), 16'(typ_exp[typ_got]));
                typ_got++;
                pop();
            end
        end
        chk("typ_count", 16'(typ_got), 16'(typ_n));

        // ---- reset mid-sequence drops prefix and queued events
        send(8'h11); send(8'h22); send(8'h33);
        send(8'hE0);
        chk("pre_rst_vld", 16'(evt_valid), 16'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_vld", 16'(evt_valid), 16'h0);
        send(8'h75);
        expect_pop("post_rst_75", 10'h075);
        chk("post_rst_empty", 16'(evt_valid), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
